// File: rtl/ps2_rx_pkg.sv
// Shared types and helpers for the PS/2 frame receiver.
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Data is zero-extended into this width before the parity reduction.
    localparam int unsigned PARITY_MAX_W = 64;

    // True when data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PARITY_MAX_W-1:0] data,
                                           input logic                    parity_bit);
        return ^{data, parity_bit};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Show-ahead register FIFO with occupancy count and overflow pulse.
module ps2_rx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            pop,
    output logic [DATA_W-1:0]               rd_data,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            empty,
    output logic                            overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_pop;
    logic              do_push;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            overflow <= push && full && !do_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver with error detection and output FIFO.
// Define PS2_RX_PARITY_CHECK_EN to drop and flag frames with bad odd parity.
module ps2_rx_frame
    import ps2_rx_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            ps2_clk_posedge,
    input  logic                            ps2_data,
    input  logic                            rd_en,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            parity_err,
    output logic                            frame_err,
    output logic                            timeout_err,
    output logic                            overflow
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYCLES);

    state_t               state;
    state_t               state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0]    shreg;
    logic [TMR_W-1:0]     tmr;
    logic                 timeout_c;
    logic                 push_c;
    logic                 frame_err_c;
    logic                 parity_err_c;
    logic                 timeout_err_c;
    logic                 fifo_empty;
`ifdef PS2_RX_PARITY_CHECK_EN
    logic                 par_bit;
`endif

    // A posedge arriving on the last allowed cycle still counts as in time.
    assign timeout_c = (state != ST_IDLE) && !ps2_clk_posedge
                    && (tmr == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable && ps2_clk_posedge && ps2_data == START_BIT) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (!enable || timeout_c) state_nxt = ST_IDLE;
                else if (ps2_clk_posedge && bit_cnt == BIT_CNT_W'(DATA_W - 1)) state_nxt = ST_PARITY;
            end
            ST_PARITY: begin
                if (!enable || timeout_c)  state_nxt = ST_IDLE;
                else if (ps2_clk_posedge) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (!enable || timeout_c || ps2_clk_posedge) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame verdict on the stop-bit posedge; a bad stop bit outranks bad parity.
    always_comb begin
        push_c        = 1'b0;
        frame_err_c   = 1'b0;
        parity_err_c  = 1'b0;
        timeout_err_c = 1'b0;
        if (enable) begin
            if (state == ST_STOP && ps2_clk_posedge) begin
                if (ps2_data != STOP_BIT) frame_err_c = 1'b1;
`ifdef PS2_RX_PARITY_CHECK_EN
                else if (!odd_parity_ok(PARITY_MAX_W'(shreg), par_bit)) parity_err_c = 1'b1;
`endif
                else push_c = 1'b1;
            end
            timeout_err_c = timeout_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            tmr         <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_IDLE) bit_cnt <= '0;
            else if (state == ST_DATA && ps2_clk_posedge) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                shreg   <= {ps2_data, shreg[DATA_W-1:1]};
            end
            if (ps2_clk_posedge || state == ST_IDLE) tmr <= '0;
            else                                     tmr <= tmr + TMR_W'(1);
            frame_err   <= frame_err_c;
            parity_err  <= parity_err_c;
            timeout_err <= timeout_err_c;
        end
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)                                        par_bit <= 1'b0;
        else if (state == ST_PARITY && ps2_clk_posedge)   par_bit <= ps2_data;
    end
`endif

    ps2_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_c),
        .wr_data  (shreg),
        .pop      (rd_en),
        .rd_data  (rd_data),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Randomized self-checking bench for ps2_rx_frame against a frame-level queue model.
module tb_ps2_rx_frame;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned TO     = 50;
    localparam int unsigned DEPTH  = 4;
`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              ps2_clk_posedge;
    logic              ps2_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [2:0]        fifo_count;
    logic              parity_err;
    logic              frame_err;
    logic              timeout_err;
    logic              overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pe = 0, n_fe = 0, n_to = 0, n_ov = 0;
    logic [7:0] model_q[$];

    always #5 clk = ~clk;

    ps2_rx_frame #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .ps2_clk_posedge (ps2_clk_posedge),
        .ps2_data        (ps2_data),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .fifo_count      (fifo_count),
        .parity_err      (parity_err),
        .frame_err       (frame_err),
        .timeout_err     (timeout_err),
        .overflow        (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock, then sample and tally the error pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        n_pe += int'(parity_err);
        n_fe += int'(frame_err);
        n_to += int'(timeout_err);
        n_ov += int'(overflow);
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] exp_d;
        exp_d = (model_q.size() > 0) ? model_q[0] : 8'h00;
        check({tag, "_valid"}, rd_valid, model_q.size() > 0);
        check({tag, "_count"}, fifo_count, model_q.size());
        check({tag, "_data"}, rd_data, exp_d);
    endtask

    task automatic idle_cycle(input bit allow_rd);
        bit do_rd;
        ps2_clk_posedge = 1'b0;
        ps2_data        = 1'($urandom % 2);
        do_rd           = allow_rd && ($urandom % 4 == 0);
        rd_en           = do_rd;
        if (do_rd && model_q.size() > 0) check("noise_pop_head", rd_data, model_q[0]);
        tick();
        if (do_rd && model_q.size() > 0) void'(model_q.pop_front());
        rd_en = 1'b0;
    endtask

    task automatic strobe(input logic b, input logic rd);
        ps2_clk_posedge = 1'b1;
        ps2_data        = b;
        rd_en           = rd;
        tick();
        ps2_clk_posedge = 1'b0;
        rd_en           = 1'b0;
    endtask

    // Sends one complete frame and checks the verdict and FIFO state right after the stop bit.
    task automatic send_frame(input logic [7:0] d, input bit par_good, input bit stop,
                              input int unsigned max_gap, input bit rd_at_stop,
                              input bit rd_noise, input string tag);
        int         pe0, fe0, to0, ov0;
        bit         exp_pe, exp_fe, exp_ov, popped;
        logic       pbit;
        logic [10:0] bits;
        pe0 = n_pe; fe0 = n_fe; to0 = n_to; ov0 = n_ov;
        exp_pe = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0; popped = 1'b0;
        pbit = par_good ? ~(^d) : (^d);
        bits = {stop, pbit, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == 10) begin
                if (rd_at_stop && model_q.size() > 0) begin
                    check({tag, "_pop_head"}, rd_data, model_q[0]);
                    popped = 1'b1;
                end
                strobe(bits[i], rd_at_stop);
            end else begin
                strobe(bits[i], 1'b0);
                repeat ($urandom_range(max_gap, 0)) idle_cycle(rd_noise);
            end
        end
        if (popped) void'(model_q.pop_front());
        if (!stop)                        exp_fe = 1'b1;
        else if (PAR_CHK && !par_good)    exp_pe = 1'b1;
        else if (model_q.size() < DEPTH)  model_q.push_back(d);
        else                              exp_ov = 1'b1;
        check({tag, "_frame_err"},  n_fe - fe0, exp_fe);
        check({tag, "_parity_err"}, n_pe - pe0, exp_pe);
        check({tag, "_overflow"},   n_ov - ov0, exp_ov);
        check({tag, "_timeout"},    n_to - to0, 0);
        check_outputs(tag);
    endtask

    task automatic drain(input string tag);
        while (model_q.size() > 0) begin
            check({tag, "_drain_valid"}, rd_valid, 1);
            check({tag, "_drain_data"}, rd_data, model_q[0]);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            void'(model_q.pop_front());
            check({tag, "_drain_count"}, fifo_count, model_q.size());
        end
        check({tag, "_drain_empty"}, rd_valid, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int to0, pe0, fe0, ov0;
        reset = 1'b1; enable = 1'b1; ps2_clk_posedge = 1'b0; ps2_data = 1'b1; rd_en = 1'b0;
        repeat (3) tick();
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        tick();

        send_frame(8'h5A, 1'b1, 1'b1, 3, 1'b0, 1'b0, "valid");
        drain("valid");
        send_frame(8'h5A, 1'b0, 1'b1, 3, 1'b0, 1'b0, "par_bad");
        drain("par_bad");
        send_frame(8'h3C, 1'b1, 1'b0, 3, 1'b0, 1'b0, "stop_bad");
        send_frame(8'hA7, 1'b1, 1'b1, 0, 1'b0, 1'b0, "after_fe");
        drain("after_fe");

        // Timeout: start plus three data bits, then silence.
        send_frame(8'h81, 1'b1, 1'b1, 2, 1'b0, 1'b0, "pre_to");
        to0 = n_to;
        strobe(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle_cycle(1'b0);
            strobe(1'($urandom % 2), 1'b0);
        end
        repeat (TO - 1) idle_cycle(1'b0);
        check("to_not_early", n_to - to0, 0);
        idle_cycle(1'b0);
        check("to_pulse", timeout_err, 1);
        check("to_count", n_to - to0, 1);
        check_outputs("to_fifo");
        send_frame(8'hC3, 1'b1, 1'b1, 2, 1'b0, 1'b0, "after_to");
        drain("after_to");

        // Overflow, then the same sequence with a pop on the fifth push.
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 1'b1, 1, 1'b0, 1'b0, "ovf");
        drain("ovf");
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 1'b1, 1, v == 5, 1'b0, "ovf_pop");
        drain("ovf_pop");

        // Abort by dropping enable after four data bits.
        pe0 = n_pe; fe0 = n_fe; to0 = n_to; ov0 = n_ov;
        strobe(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
        enable = 1'b0;
        repeat (3) idle_cycle(1'b0);
        strobe(1'b0, 1'b0);
        enable = 1'b1;
        idle_cycle(1'b0);
        check("abort_errs", (n_pe - pe0) + (n_fe - fe0) + (n_to - to0) + (n_ov - ov0), 0);
        check_outputs("abort");
        send_frame(8'h96, 1'b1, 1'b1, 2, 1'b0, 1'b0, "after_abort");

        // Reset in the middle of a frame with a non-empty FIFO.
        strobe(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
        reset = 1'b1;
        tick();
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_fifo_count", fifo_count, 0);
        check("mid_rst_pulses", {parity_err, frame_err, timeout_err, overflow}, 0);
        reset = 1'b0;
        model_q.delete();
        tick();
        send_frame(8'h42, 1'b1, 1'b1, 2, 1'b0, 1'b0, "after_rst");
        drain("after_rst");

        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom), ($urandom % 4) != 0, ($urandom % 5) != 0, 3,
                       1'($urandom % 2), 1'b1, "rnd");
            if (n % 10 == 9) drain("rnd");
        end
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
